relu_layer_seq: RTL and testbench

Sequencer that applies the ReLU activation in place or out of place over one layer's output buffer. It walks `length` N-bit fixed-point words starting at `src_base`, reads each word through a 1-cycle-latency memory read port, and clamps negatives to zero. It writes each result to `dst_base + i` through a write port with backpressure, counts the clamped elements, and pulses `done` at the end. It sits between the layer accumulator buffer and the next layer's input fetch, driven by the top-level inference controller.

---
 rtl/relu_pkg.sv | 16 +
 rtl/relu_clamp.sv | 16 +
 rtl/relu_layer_seq.sv | 118 +++++++++++
 tb/tb_relu_layer_seq.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relu_pkg.sv
// Shared definitions for the ReLU layer sequencer.
package relu_pkg;

  localparam int unsigned QDef  = 15;
  localparam int unsigned NDef  = 32;
  localparam int unsigned AwDef = 10;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWt,
    StWr,
    StDone
  } relu_seq_state_t;

endpackage

// File: rtl/relu_clamp.sv
// Combinational ReLU on a two's complement word: negatives become zero.
module relu_clamp #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic         clamped
);

  // Sign bit alone decides; zero passes through and is not reported as clamped.
  always_comb begin
    clamped = din[N-1];
    dout    = din[N-1] ? '0 : din;
  end

endmodule

// File: rtl/relu_layer_seq.sv
// Walks a buffer of fixed-point words, applies ReLU and writes the results out,
// counting how many elements were clamped.
module relu_layer_seq
  import relu_pkg::*;
#(
  parameter int unsigned Q  = QDef,
  parameter int unsigned N  = NDef,
  parameter int unsigned AW = AwDef
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  input  logic [AW-1:0] length,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] clamped_count,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [N-1:0]  rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [N-1:0]  wr_data,
  input  logic          wr_ready
);

  // Q only describes the number format; reject a nonsensical one at elaboration.
  if (Q >= N) begin : g_q_check
    $error("Q must be smaller than N");
  end

  relu_seq_state_t state_q, state_d;

  logic [AW-1:0] src_q, dst_q, len_q, idx_q, count_q;
  logic [N-1:0]  result_q;
  logic [N-1:0]  clamp_out;
  logic          clamp_hit;
  logic          last_elem;

  relu_clamp #(
    .N(N)
  ) u_clamp (
    .din    (rd_data),
    .dout   (clamp_out),
    .clamped(clamp_hit)
  );

  assign last_elem = (idx_q == len_q - AW'(1));

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = (length != '0) ? StRd : StDone;
      end
      StRd:   state_d = StWt;
      StWt:   state_d = StWr;
      StWr: begin
        if (wr_ready) state_d = last_elem ? StDone : StRd;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Operand latch, element index, result capture and clamp counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            src_q   <= src_base;
            dst_q   <= dst_base;
            len_q   <= length;
            idx_q   <= '0;
            count_q <= '0;
          end
        end
        StWt: begin
          result_q <= clamp_out;
          if (clamp_hit) count_q <= count_q + AW'(1);
        end
        StWr: begin
          if (wr_ready && !last_elem) idx_q <= idx_q + AW'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs come only from state and registers; addresses wrap modulo 2^AW.
  always_comb begin
    busy          = (state_q != StIdle);
    done          = (state_q == StDone);
    rd_en         = (state_q == StRd);
    wr_en         = (state_q == StWr);
    rd_addr       = src_q + idx_q;
    wr_addr       = dst_q + idx_q;
    wr_data       = result_q;
    clamped_count = count_q;
  end

endmodule

// File: tb/tb_relu_layer_seq.sv
// Self-checking bench for relu_layer_seq: table of runs, read/write scoreboards,
// plus hand-written reset-in-stall sequence.
module tb_relu_layer_seq;

  localparam int unsigned N  = 32;
  localparam int unsigned AW = 10;

  typedef struct {
    logic [N-1:0] din;
    logic [N-1:0] dout;
  } elem_t;

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW-1:0] len;
    int            e0;
    int            stall_elem;
    int            stall_n;
    bit            inject;
    int            exp_done;
    int            exp_clamp;
  } run_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [N-1:0]  data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic [AW-1:0] length = '0;
  logic          busy, done, rd_en, wr_en;
  logic [AW-1:0] clamped_count, rd_addr, wr_addr;
  logic [N-1:0]  rd_data = '0;
  logic [N-1:0]  wr_data;
  logic          wr_ready = 1'b1;

  relu_layer_seq #(
    .Q (15),
    .N (N),
    .AW(AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .src_base     (src_base),
    .dst_base     (dst_base),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .clamped_count(clamped_count),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model with one cycle of read latency.
  logic [N-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Scoreboards and run bookkeeping.
  logic [AW-1:0] rd_q[$];
  wr_t           wr_q[$];
  int            rd_seen = 0;
  int            wr_seen = 0;
  int            wr_count = 0;
  int            stall_elem = -1;
  int            stall_left = 0;
  bit            prev_stall = 0;
  wr_t           held;

  // Backpressure generator: holds wr_ready low for the selected write.
  always @(negedge clk) begin
    if (wr_en && wr_count == stall_elem && stall_left > 0) begin
      wr_ready = 1'b0;
      stall_left--;
    end else begin
      wr_ready = 1'b1;
    end
  end

  // Traffic monitor: sampled just after the falling edge.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (rd_en) begin
        rd_seen++;
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected read: got rd_addr 0x%0h, expected no read", rd_addr);
        end else begin
          check("rd_addr", rd_addr, rd_q.pop_front());
        end
      end
      if (wr_en) begin
        if (prev_stall) begin
          check("stalled wr_addr", wr_addr, held.addr);
          check("stalled wr_data", wr_data, held.data);
        end
        if (wr_ready) begin
          wr_t e;
          wr_seen++;
          wr_count++;
          prev_stall = 0;
          if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected write: got addr 0x%0h data 0x%0h, expected none",
                     wr_addr, wr_data);
          end else begin
            e = wr_q.pop_front();
            check("wr_addr", wr_addr, e.addr);
            check("wr_data", wr_data, e.data);
          end
        end else begin
          prev_stall = 1;
          held.addr  = wr_addr;
          held.data  = wr_data;
        end
      end else begin
        prev_stall = 0;
      end
    end
  end

  elem_t tbl[7];
  run_t  runs[5];

  task automatic check_zero(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " rd_en"}, rd_en, 0);
    check({tag, " wr_en"}, wr_en, 0);
    check({tag, " rd_addr"}, rd_addr, 0);
    check({tag, " wr_addr"}, wr_addr, 0);
    check({tag, " wr_data"}, wr_data, 0);
    check({tag, " clamped_count"}, clamped_count, 0);
  endtask

  // Load memory, push expectations and pulse start; returns the cycle-0 count.
  task automatic launch(input run_t r, output int c0);
    rd_q.delete();
    wr_q.delete();
    rd_seen    = 0;
    wr_seen    = 0;
    wr_count   = 0;
    stall_elem = r.stall_elem;
    stall_left = r.stall_n;
    for (int i = 0; i < int'(r.len); i++) begin
      logic [AW-1:0] ra, wa;
      wr_t           w;
      ra = r.src + AW'(i);
      wa = r.dst + AW'(i);
      mem[ra] = tbl[r.e0 + i].din;
      rd_q.push_back(ra);
      w.addr = wa;
      w.data = tbl[r.e0 + i].dout;
      wr_q.push_back(w);
    end
    @(negedge clk);
    start    = 1'b1;
    src_base = r.src;
    dst_base = r.dst;
    length   = r.len;
    c0       = cyc;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic do_run(input string name, input run_t r);
    int c0;
    bit got;
    bit injected;
    got      = 0;
    injected = 0;
    launch(r, c0);
    for (int k = 0; k < 300; k++) begin
      if (done) begin
        got = 1;
        break;
      end
      if (r.inject && !injected && wr_en && wr_count == 1) begin
        start    = 1'b1;
        src_base = 10'h100;
        dst_base = 10'h300;
        length   = 10'd2;
        injected = 1;
        @(negedge clk);
        start    = 1'b0;
        src_base = r.src;
        dst_base = r.dst;
        length   = r.len;
        #1;
        continue;
      end
      @(negedge clk);
      #1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s done timeout: got no done, expected done in cycle %0d", name, r.exp_done);
    end else begin
      check({name, " done cycle"}, cyc - c0, r.exp_done);
      check({name, " clamped_count"}, clamped_count, r.exp_clamp);
      check({name, " reads"}, rd_seen, int'(r.len));
      check({name, " writes"}, wr_seen, int'(r.len));
      check({name, " writes left"}, wr_q.size(), 0);
    end
    @(negedge clk);
    #1;
    check({name, " idle after done"}, {busy, done}, 2'b00);
    check({name, " clamped_count hold"}, clamped_count, r.exp_clamp);
  endtask

  initial begin
    int   c0;
    bit   got;
    run_t rr;

    tbl[0] = '{din: 32'h0001_8000, dout: 32'h0001_8000};
    tbl[1] = '{din: 32'hFFFF_8000, dout: 32'h0000_0000};
    tbl[2] = '{din: 32'h0000_0000, dout: 32'h0000_0000};
    tbl[3] = '{din: 32'h8000_0000, dout: 32'h0000_0000};
    tbl[4] = '{din: 32'h7FFF_FFFF, dout: 32'h7FFF_FFFF};
    tbl[5] = '{din: 32'h0000_0001, dout: 32'h0000_0001};
    tbl[6] = '{din: 32'hFFFF_FFFF, dout: 32'h0000_0000};

    runs[0] = '{src: 10'h010, dst: 10'h200, len: 10'd4, e0: 0, stall_elem: -1, stall_n: 0,
                inject: 0, exp_done: 13, exp_clamp: 2};
    runs[1] = '{src: 10'h010, dst: 10'h200, len: 10'd0, e0: 0, stall_elem: -1, stall_n: 0,
                inject: 0, exp_done: 1, exp_clamp: 0};
    runs[2] = '{src: 10'h010, dst: 10'h200, len: 10'd4, e0: 0, stall_elem: 1, stall_n: 3,
                inject: 0, exp_done: 16, exp_clamp: 2};
    runs[3] = '{src: 10'h3FE, dst: 10'h3FF, len: 10'd3, e0: 4, stall_elem: -1, stall_n: 0,
                inject: 0, exp_done: 10, exp_clamp: 1};
    runs[4] = '{src: 10'h010, dst: 10'h200, len: 10'd4, e0: 0, stall_elem: -1, stall_n: 0,
                inject: 1, exp_done: 13, exp_clamp: 2};

    for (int a = 0; a < (1 << AW); a++) mem[a] = 32'hDEAD_0000 | a;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 5; r++) do_run($sformatf("run%0d", r), runs[r]);

    // Reset asserted while a write is stalled.
    rr = '{src: 10'h010, dst: 10'h200, len: 10'd4, e0: 0, stall_elem: 1, stall_n: 1000,
           inject: 0, exp_done: 0, exp_clamp: 0};
    launch(rr, c0);
    got = 0;
    for (int k = 0; k < 100; k++) begin
      if (wr_en && !wr_ready) begin
        got = 1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL stall before reset: got no stalled write, expected one");
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async reset");
    rd_q.delete();
    wr_q.delete();
    stall_left = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle after reset release", busy, 0);

    rr = '{src: 10'h020, dst: 10'h210, len: 10'd1, e0: 0, stall_elem: -1, stall_n: 0,
           inject: 0, exp_done: 4, exp_clamp: 0};
    do_run("post-reset", rr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard backstop so the bench never hangs.
  initial begin
    #200000;
    $display("FAIL global timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
